// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard for hazard control.
// Optional write-through forwarding is enabled by defining RF_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              we4,
  input  logic [ADDR_W-1:0] wa4,
  input  logic [DATA_W-1:0] wd4,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              busy_any
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Issue beats writeback on the busy bit: the newer producer owns the register.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (we3 && wa3 == ADDR_W'(r))
        mem_d[r] = wd3;
      else if (we4 && wa4 == ADDR_W'(r))
        mem_d[r] = wd4;

      if (iss_en && iss_addr == ADDR_W'(r))
        busy_d[r] = 1'b1;
      else if ((we3 && wa3 == ADDR_W'(r)) || (we4 && wa4 == ADDR_W'(r)))
        busy_d[r] = 1'b0;
    end
    if (ZERO_REG != 0) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end

  // NOTE: the storage array is reset on purpose; the block must present
  // zeros for every address while rst is held, so it cannot map to a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic              bz [2];

  assign ra[0] = ra1;
  assign ra[1] = ra2;

  always_comb begin
    logic hit3, hit4, hit_iss;
    hit3    = 1'b0;
    hit4    = 1'b0;
    hit_iss = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rd[p] = mem_q[ra[p]];
      bz[p] = busy_q[ra[p]];
`ifdef RF_BYPASS_EN
      hit3    = !rst && we3 && (wa3 == ra[p]);
      hit4    = !rst && we4 && (wa4 == ra[p]);
      hit_iss = iss_en && (iss_addr == ra[p]);
      if (hit3)
        rd[p] = wd3;
      else if (hit4)
        rd[p] = wd4;
      if ((hit3 || hit4) && !hit_iss)
        bz[p] = 1'b0;
`endif
      if (ZERO_REG != 0 && ra[p] == '0) begin
        rd[p] = '0;
        bz[p] = 1'b0;
      end
    end
  end

  assign rd1      = rd[0];
  assign rd2      = rd[1];
  assign busy1    = bz[0];
  assign busy2    = bz[1];
  assign busy_any = |busy_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port register file for the pipelined MIPS datapath: two combinational read ports, two synchronous write ports, asynchronous clear.
- Adds a per-register scoreboard (busy bits) used by hazard control to stall consumers of in-flight results.
- Register 0 can be hardwired to zero.
- Sits between decode (reads, issue) and writeback (ALU port, load port).

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and never becomes busy; when 0 it is an ordinary register.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- ra1  in  ADDR_W  read address port 1.
- ra2  in  ADDR_W  read address port 2.
- rd1  out  DATA_W  read data port 1.
- rd2  out  DATA_W  read data port 2.
- we3  in  1  write enable, port A (ALU writeback).
- wa3  in  ADDR_W  write address, port A.
- wd3  in  DATA_W  write data, port A.
- we4  in  1  write enable, port B (load writeback).
- wa4  in  ADDR_W  write address, port B.
- wd4  in  DATA_W  write data, port B.
- iss_en  in  1  issue strobe: mark iss_addr busy.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- busy1  out  1  scoreboard busy bit for ra1.
- busy2  out  1  scoreboard busy bit for ra2.
- busy_any  out  1  OR of all busy bits (pipeline drain indicator).

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - all 2**ADDR_W registers cleared to 0; all busy bits cleared.
  - hence rd1=rd2=0, busy1=busy2=busy_any=0 while rst is held.
- Reads: rd1/rd2 combinational from storage, zero latency.
  - Both ports may read the same address.
  - With ZERO_REG=1, address 0 returns 0 regardless of storage.
- Writes: on posedge clk, each enabled port writes its register; the new value is visible on reads after the edge.
  - we3 and we4 to the same address in the same cycle: port A (wd3) wins, port B is dropped.
  - Writes to different addresses both commit.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Scoreboard, per register bit, on posedge:
  - set if iss_en && iss_addr==r.
  - else cleared if (we3 && wa3==r) || (we4 && wa4==r).
  - else held.
  - Issue and writeback to the same register in the same cycle: bit ends set (the newer producer wins).
  - A writeback to a register that is not busy is legal and leaves the bit clear.
  - With ZERO_REG=1, bit 0 is constant 0.
- busy1/busy2 are combinational lookups of the busy bits at ra1/ra2; busy_any is combinational.
- rst asserted mid-operation: any in-progress write is lost, state is cleared immediately, and operation resumes on the first edge after deassertion.
- No X on outputs after reset for any address.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through forwarding.
  - If a port writes the address being read in the same cycle, rd1/rd2 return the write data combinationally, with port-A priority over port B.
  - busy1/busy2 are masked to 0 when that register is being written this cycle and not being re-issued this cycle.
  - Address 0 is still forced to zero when ZERO_REG=1.
- Undefined: rd/busy reflect stored state only; the written value and the cleared busy bit appear one cycle after the write edge.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then pulse rst asynchronously between edges -> rd1(ra1=5)=0 immediately, busy_any=0.
- Basic write/read: we3=1, wa3=7, wd3=0x12345678; next cycle ra1=7, ra2=7 -> rd1=rd2=0x12345678. Write r0=0xFFFFFFFF with ZERO_REG=1 -> rd1(ra1=0)=0.
- Dual write collision: we3=we4=1, wa3=wa4=9, wd3=0xAAAA0000, wd4=0x5555FFFF -> r9=0xAAAA0000. Repeat with wa4=10 -> r9 and r10 both updated.
- Scoreboard lifecycle: iss_en, iss_addr=3 -> busy1(ra1=3)=1 next cycle; we4, wa4=3 -> busy1=0 the cycle after; busy_any toggles accordingly.
- Issue/writeback same cycle: r3 busy; iss_en, iss_addr=3 together with we3, wa3=3 -> busy stays 1 and r3 holds the written data.
- Bypass (RF_BYPASS_EN defined): we3, wa3=4, wd3=0xCAFEF00D with ra2=4 in the same cycle -> rd2=0xCAFEF00D before the edge. Without the macro -> rd2 shows the old r4 value until after the edge.
